// File: rtl/axi_wr_burst_slave.sv
// ----------------------------------------------------------------------------
// axi_wr_burst_slave
//
// AXI4 write-channel slave endpoint. It handles one burst at a time and turns
// each accepted W beat into a single word write on a simple memory port.
// FIXED, INCR and WRAP bursts are supported. Illegal or out-of-range requests
// still drain every beat, but no memory writes are issued, and the burst is
// answered with SLVERR.
//
// Ports
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   AW*  (ID/ADDR/LEN/SIZE/BURST/VALID/READY)   write address channel
//   W*   (DATA/STRB/LAST/VALID/READY)           write data channel
//   B*   (ID/RESP/VALID/READY)                  write response channel
//   mem_we, mem_addr, mem_wdata, mem_wstrb      word-wide memory write port
// ----------------------------------------------------------------------------
module axi_wr_burst_slave #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    parameter  int ID_WIDTH   = 4,
    parameter  int MEM_DEPTH  = 1024,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int MEM_AW     = $clog2(MEM_DEPTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // write address channel
    input  logic [ID_WIDTH-1:0]   AWID,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    // write data channel
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [STRB_WIDTH-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    // write response channel
    output logic [ID_WIDTH-1:0]   BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    // memory port
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wstrb
);

    localparam int SIZE_LOG = $clog2(STRB_WIDTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_RESP
    } state_t;

    state_t                state_q, state_next;
    logic [ID_WIDTH-1:0]   id_q;
    logic [MEM_AW-1:0]     addr_q;
    logic [7:0]            len_q;
    logic [1:0]            burst_q;
    logic                  err_q;
    logic [7:0]            beat_cnt;

    logic                  aw_hs, w_hs, b_hs;
    logic                  last_beat;
    logic                  aw_err;
    logic [ADDR_WIDTH-1:0] aw_word;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [MEM_AW:0]       incr_addr;
    logic [MEM_AW-1:0]     wrap_mask;
    logic [MEM_AW-1:0]     addr_next;
    logic                  overrun;

    assign aw_hs     = AWVALID & AWREADY;
    assign w_hs      = WVALID & WREADY;
    assign b_hs      = BVALID & BREADY;
    assign last_beat = (beat_cnt == len_q);

    // Request legality, evaluated on the live AW inputs so the flag can be
    // captured together with the request.
    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        aw_word    = AWADDR >> SIZE_LOG;
        align_mask = (ADDR_WIDTH'(1) << AWSIZE) - ADDR_WIDTH'(1);
        aw_err     = 1'b0;
        if (AWSIZE != 3'(SIZE_LOG))
            aw_err = 1'b1;
        if (AWBURST == BURST_RSVD)
            aw_err = 1'b1;
        if (AWBURST == BURST_WRAP &&
            AWLEN != 8'd1 && AWLEN != 8'd3 && AWLEN != 8'd7 && AWLEN != 8'd15)
            aw_err = 1'b1;
        if (aw_word >= ADDR_WIDTH'(MEM_DEPTH))
            aw_err = 1'b1;
        if ((AWADDR & align_mask) != '0)
            aw_err = 1'b1;
    end

    // Address for the following beat. The increment carries one extra bit so
    // that running past the end of memory is visible even when MEM_DEPTH is a
    // power of two and the stored address would silently wrap to zero.
    always_comb begin
        incr_addr = {1'b0, addr_q} + (MEM_AW + 1)'(1);
        wrap_mask = MEM_AW'(len_q);
        addr_next = addr_q;
        overrun   = 1'b0;
        case (burst_q)
            BURST_INCR: begin
                addr_next = incr_addr[MEM_AW-1:0];
                overrun   = (incr_addr >= (MEM_AW + 1)'(MEM_DEPTH));
            end
            BURST_WRAP: begin
                // Only the bits inside the (len+1)-word window advance.
                addr_next = (addr_q & ~wrap_mask) | (incr_addr[MEM_AW-1:0] & wrap_mask);
            end
            BURST_FIXED: addr_next = addr_q;
            default:     addr_next = addr_q;
        endcase
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE:  if (aw_hs)             state_next = S_DATA;
            S_DATA:  if (w_hs && last_beat) state_next = S_RESP;
            S_RESP:  if (b_hs)              state_next = S_IDLE;
            default:                        state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the control flops must come out of reset in a known state; the
    // datapath captures are reset as well so BID reads 0 after reset.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= S_IDLE;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= BURST_FIXED;
            err_q    <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state_q <= state_next;
            // Handshake readies are registered images of the next state, so
            // AWREADY first rises one edge after reset release.
            AWREADY <= (state_next == S_IDLE);
            WREADY  <= (state_next == S_DATA);
            BVALID  <= (state_next == S_RESP);

            if (aw_hs) begin
                id_q     <= AWID;
                addr_q   <= MEM_AW'(aw_word);
                len_q    <= AWLEN;
                burst_q  <= AWBURST;
                err_q    <= aw_err;
                beat_cnt <= '0;
            end

            if (w_hs) begin
                addr_q   <= addr_next;
                beat_cnt <= beat_cnt + 8'd1;
                // A WLAST that disagrees with the count poisons the response;
                // an INCR walking off the end poisons all remaining beats.
                // Overrun after the final beat is harmless and ignored.
                if ((WLAST != last_beat) || (overrun && !last_beat))
                    err_q <= 1'b1;
            end
        end
    end

    assign BID       = id_q;
    assign BRESP     = {BVALID & err_q, 1'b0};

    assign mem_we    = w_hs & ~err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = WDATA;
    assign mem_wstrb = WSTRB;

endmodule

// File: tb/tb_axi_wr_burst_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_wr_burst_slave
//
// Drives directed and randomized AXI write bursts into axi_wr_burst_slave and
// compares memory-port writes and B responses against a burst-level model
// that derives word addresses and errors arithmetically from the request.
// ----------------------------------------------------------------------------
module tb_axi_wr_burst_slave;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int MEM_DEPTH  = 1024;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int MEM_AW     = $clog2(MEM_DEPTH);
    localparam int ENT_W      = MEM_AW + DATA_WIDTH + STRB_WIDTH;

    logic                  ACLK;
    logic                  ARESETn;
    logic [ID_WIDTH-1:0]   AWID;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    logic [ID_WIDTH-1:0]   BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic                  mem_we;
    logic [MEM_AW-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [STRB_WIDTH-1:0] mem_wstrb;

    int vectors    = 0;
    int miscompares = 0;

    logic [ENT_W-1:0] got_q[$];

    axi_wr_burst_slave #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .ID_WIDTH  (ID_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .AWID     (AWID),
        .AWADDR   (AWADDR),
        .AWLEN    (AWLEN),
        .AWSIZE   (AWSIZE),
        .AWBURST  (AWBURST),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WLAST    (WLAST),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BID      (BID),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // A write is committed on the rising edge following this sample.
    always @(negedge ACLK) begin
        if (ARESETn && mem_we)
            got_q.push_back({mem_addr, mem_wdata, mem_wstrb});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // Waits (bounded) until the selected DUT output is high at a falling edge:
    // 0 = AWREADY, 1 = WREADY, 2 = BVALID.
    task automatic wait_sig(input int which, input string tag);
        int n = 0;
        forever begin
            @(negedge ACLK);
            if ((which == 0 && AWREADY) || (which == 1 && WREADY) || (which == 2 && BVALID))
                break;
            n++;
            if (n > 100) begin
                check({tag, "_timeout"}, 64'd0, 64'd1);
                finish_run();
            end
        end
    endtask

    // One complete burst with model prediction.
    //   strb_sel : 0 all ones, 1 one-hot walking, 2 random
    //   bad_last : -1 normal, -2 never assert WLAST, k>=0 also assert WLAST on beat k
    //   bdelay   : cycles BREADY is held low once BVALID is seen
    task automatic run_burst(input string tag,
                             input logic [ID_WIDTH-1:0]   id,
                             input logic [ADDR_WIDTH-1:0] addr,
                             input logic [7:0]            len,
                             input logic [2:0]            size,
                             input logic [1:0]            burst,
                             input int                    strb_sel,
                             input logic [DATA_WIDTH-1:0] data_base,
                             input int                    bad_last,
                             input int                    bdelay);
        logic [DATA_WIDTH-1:0] data_a[256];
        logic [STRB_WIDTH-1:0] strb_a[256];
        logic                  last_a[256];
        logic [ENT_W-1:0]      exp_q[$];
        logic                  err;
        int                    n, start, base, w;

        n = int'(len) + 1;
        for (int i = 0; i < n; i++) begin
            data_a[i] = data_base + DATA_WIDTH'(i);
            case (strb_sel)
                0:       strb_a[i] = '1;
                1:       strb_a[i] = STRB_WIDTH'(1 << (i % STRB_WIDTH));
                default: strb_a[i] = STRB_WIDTH'($urandom);
            endcase
            if (bad_last == -2) last_a[i] = 1'b0;
            else                last_a[i] = (i == n - 1) || (i == bad_last);
        end

        // Reference: word sequence and error outcome from the burst rules.
        start = int'(addr >> $clog2(STRB_WIDTH));
        err   = 1'b0;
        if (int'(size) != $clog2(STRB_WIDTH)) err = 1'b1;
        if (burst == 2'b11) err = 1'b1;
        if (burst == 2'b10 && !(n == 2 || n == 4 || n == 8 || n == 16)) err = 1'b1;
        if (start >= MEM_DEPTH) err = 1'b1;
        if ((int'(addr) % (1 << size)) != 0) err = 1'b1;
        base = start - (start % n);
        for (int i = 0; i < n; i++) begin
            case (burst)
                2'b01:   w = start + i;
                2'b10:   w = base + ((start - base + i) % n);
                default: w = start;
            endcase
            if (burst == 2'b01 && w >= MEM_DEPTH) err = 1'b1;
            if (!err) exp_q.push_back({MEM_AW'(w), data_a[i], strb_a[i]});
            if (last_a[i] != (i == n - 1)) err = 1'b1;
        end

        got_q.delete();

        @(posedge ACLK); #1;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
        AWVALID = 1'b1;
        wait_sig(0, {tag, "_aw"});
        @(posedge ACLK); #1;
        AWVALID = 1'b0;

        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) begin
                WVALID = 1'b0;
                @(posedge ACLK); #1;
            end
            WVALID = 1'b1; WDATA = data_a[i]; WSTRB = strb_a[i]; WLAST = last_a[i];
            wait_sig(1, {tag, "_w"});
            @(posedge ACLK); #1;
            WVALID = 1'b0; WLAST = 1'b0;
        end

        wait_sig(2, {tag, "_b"});
        check({tag, "_wready_low"}, 64'(WREADY), 64'd0);
        for (int k = 0; k < bdelay; k++) begin
            check({tag, "_hold_bvalid"}, 64'(BVALID), 64'd1);
            check({tag, "_hold_bresp"}, 64'(BRESP), 64'(err ? 2'b10 : 2'b00));
            check({tag, "_hold_awready"}, 64'(AWREADY), 64'd0);
            @(negedge ACLK);
        end
        check({tag, "_bid"}, 64'(BID), 64'(id));
        check({tag, "_bresp"}, 64'(BRESP), 64'(err ? 2'b10 : 2'b00));
        @(posedge ACLK); #1;
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        @(negedge ACLK);
        check({tag, "_bvalid_clr"}, 64'(BVALID), 64'd0);
        check({tag, "_awready_back"}, 64'(AWREADY), 64'd1);

        check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        logic [7:0]            len;
        logic [1:0]            burst;
        logic [2:0]            size;
        logic [ADDR_WIDTH-1:0] addr;
        int                    bad;
        int                    pick;

        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;

        // Reset values and AWREADY timing around release.
        #12;
        check("rst_awready", 64'(AWREADY), 64'd0);
        check("rst_wready",  64'(WREADY),  64'd0);
        check("rst_bvalid",  64'(BVALID),  64'd0);
        check("rst_bid",     64'(BID),     64'd0);
        check("rst_bresp",   64'(BRESP),   64'd0);
        #10 ARESETn = 1'b1;
        #1  check("rel_awready_pre", 64'(AWREADY), 64'd0);
        @(negedge ACLK);
        check("rel_awready_post", 64'(AWREADY), 64'd1);

        // Directed cases.
        run_burst("incr",       4'h5, 32'h10,  8'd3, 3'd2, 2'b01, 0, 32'hA0, -1, 0);
        run_burst("wrap4",      4'h6, 32'h38,  8'd3, 3'd2, 2'b10, 2, 32'hB0, -1, 0);
        run_burst("wrap3_err",  4'h7, 32'h38,  8'd2, 3'd2, 2'b10, 2, 32'hC0, -1, 0);
        run_burst("fixed",      4'h8, 32'h20,  8'd2, 3'd2, 2'b00, 1, 32'hD0, -1, 0);
        run_burst("early_last", 4'h9, 32'h40,  8'd3, 3'd2, 2'b01, 0, 32'hE0,  1, 0);
        run_burst("no_last",    4'h2, 32'h80,  8'd1, 3'd2, 2'b01, 0, 32'hE8, -2, 0);
        run_burst("narrow",     4'hA, 32'h40,  8'd1, 3'd1, 2'b01, 0, 32'hF0, -1, 0);
        run_burst("overrun",    4'hB, 32'(4 * (MEM_DEPTH - 2)), 8'd3, 3'd2, 2'b01, 2, 32'h100, -1, 5);
        run_burst("end_exact",  4'h1, 32'(4 * (MEM_DEPTH - 2)), 8'd1, 3'd2, 2'b01, 0, 32'h180, -1, 0);
        run_burst("misalign",   4'hC, 32'h12,  8'd0, 3'd2, 2'b01, 0, 32'h110, -1, 0);
        run_burst("rsvd_burst", 4'hD, 32'h50,  8'd1, 3'd2, 2'b11, 0, 32'h120, -1, 0);
        run_burst("beyond_mem", 4'hE, 32'(4 * MEM_DEPTH), 8'd0, 3'd2, 2'b01, 0, 32'h130, -1, 0);

        // Reset during the second beat: async clear, no B, earlier write kept.
        got_q.delete();
        @(posedge ACLK); #1;
        AWID = 4'h3; AWADDR = 32'h100; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01;
        AWVALID = 1'b1;
        wait_sig(0, "rst_mid_aw");
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        WVALID = 1'b1; WDATA = 32'h5555_0000; WSTRB = '1; WLAST = 1'b0;
        wait_sig(1, "rst_mid_w0");
        @(posedge ACLK); #1;
        WDATA = 32'h5555_0001;
        #1 ARESETn = 1'b0;
        #1;
        check("rst_mid_awready", 64'(AWREADY), 64'd0);
        check("rst_mid_wready",  64'(WREADY),  64'd0);
        check("rst_mid_bvalid",  64'(BVALID),  64'd0);
        WVALID = 1'b0;
        repeat (2) begin
            @(negedge ACLK);
            check("rst_mid_no_b", 64'(BVALID), 64'd0);
        end
        @(posedge ACLK); #3 ARESETn = 1'b1;
        @(negedge ACLK);
        check("rst_mid_awready_pre", 64'(AWREADY), 64'd0);
        @(negedge ACLK);
        check("rst_mid_awready_post", 64'(AWREADY), 64'd1);
        check("rst_mid_bvalid_idle", 64'(BVALID), 64'd0);
        check("rst_mid_nwrites", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0)
            check("rst_mid_write", 64'(got_q[0]), 64'({MEM_AW'(64), 32'h5555_0000, 4'hF}));
        run_burst("after_rst", 4'h4, 32'h200, 8'd2, 3'd2, 2'b01, 2, 32'h300, -1, 0);

        // Randomized bursts, mostly legal.
        for (int t = 0; t < 40; t++) begin
            pick = int'($urandom_range(9));
            burst = (pick == 0) ? 2'b11 : 2'($urandom_range(2));
            if (burst == 2'b10) begin
                case ($urandom_range(4))
                    0: len = 8'd1;
                    1: len = 8'd3;
                    2: len = 8'd7;
                    3: len = 8'd15;
                    default: len = 8'($urandom_range(15));
                endcase
            end else begin
                len = 8'($urandom_range(15));
            end
            size = ($urandom_range(9) == 0) ? 3'($urandom_range(3)) : 3'd2;
            addr = 32'($urandom_range(MEM_DEPTH - 1)) << 2;
            if ($urandom_range(9) == 0) addr = addr | 32'($urandom_range(3));
            bad = ($urandom_range(9) == 0) ? int'($urandom_range(int'(len))) : -1;
            run_burst("rand", 4'($urandom), addr, len, size, burst, 2, 32'($urandom),
                      bad, int'($urandom_range(3)));
        end

        finish_run();
    end

endmodule

// File: doc/axi_wr_burst_slave.md
Name: axi_wr_burst_slave

Overview:
- Parametrised AXI4 write-channel slave endpoint: accepts AW, W and B channel transactions and turns them into per-beat word writes on a simple memory port.
- Supports FIXED, INCR and WRAP bursts, byte strobes, configurable ID and widths, and SLVERR reporting.
- Sits between the AXI interconnect and on-chip RAM; it is the DUT driven by the master agent in the AXI bench.
- Successor to the single-width write path: generalised in DATA_WIDTH, ADDR_WIDTH, ID_WIDTH and MEM_DEPTH, and adds WRAP bursts and protocol-error detection.

Parameters:
- DATA_WIDTH, 32, W data width in bits (8/16/32/64/128); STRB_WIDTH = DATA_WIDTH/8.
- ADDR_WIDTH, 32, AXI byte-address width.
- ID_WIDTH, 4, AWID/BID width.
- MEM_DEPTH, 1024, number of DATA_WIDTH words behind mem port; MEM_AW = clog2(MEM_DEPTH).

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- AWID  in  ID_WIDTH  write id.
- AWADDR  in  ADDR_WIDTH  start byte address.
- AWLEN  in  8  beats-1.
- AWSIZE  in  3  bytes/beat = 2**AWSIZE.
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- AWVALID  in  1 / AWREADY  out  1  address handshake.
- WDATA  in  DATA_WIDTH / WSTRB  in  STRB_WIDTH / WLAST  in  1 / WVALID  in  1 / WREADY  out  1  write data channel.
- BID  out  ID_WIDTH / BRESP  out  2 / BVALID  out  1 / BREADY  in  1  write response channel.
- mem_we  out  1  word write strobe.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_wstrb  out  STRB_WIDTH  byte enables.

Behaviour:
- Reset (async assert, sync release): state IDLE, AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=00, internal error flag and beat counter cleared. AWREADY rises on the first ACLK edge after ARESETn deasserts.
- FSM IDLE -> DATA -> RESP -> IDLE; one burst in flight, no AW acceptance outside IDLE.
- IDLE: AWREADY=1. AWVALID&AWREADY captures AWID, word address (AWADDR >> log2(STRB_WIDTH)), AWLEN, AWBURST and the error flag. Next cycle: DATA, AWREADY=0, WREADY=1.
- Error flag is set at AW capture if any of the following holds:
  - AWSIZE != log2(STRB_WIDTH) (narrow transfers unsupported).
  - AWBURST == 11.
  - WRAP with AWLEN not in {1,3,7,15}.
  - Start word address >= MEM_DEPTH.
  - Start address not aligned to AWSIZE.
- DATA: each WVALID&WREADY is one beat.
  - mem_we = WVALID&WREADY&~err, combinational, same cycle.
  - mem_addr = current word address; mem_wdata = WDATA; mem_wstrb = WSTRB.
  - WSTRB=0 still asserts mem_we (no bytes written).
- Address update after each beat:
  - FIXED: unchanged.
  - INCR: +1, modulo 2**MEM_AW.
  - WRAP: low bits within the (AWLEN+1)-word aligned window wrap, upper bits held.
  - If an INCR beat address reaches >= MEM_DEPTH mid-burst, err is set from that beat on; earlier beats are already written, later beats are dropped.
- Beat counter is authoritative. On beat AWLEN+1: WREADY=0 next cycle, state RESP.
  - WLAST=1 on an earlier beat, or WLAST=0 on the final beat, sets err. The burst still completes on the count.
- Errored bursts drain all beats with mem_we held 0.
- RESP: BVALID=1, BID=captured AWID, BRESP = err ? 10 (SLVERR) : 00 (OKAY). BVALID/BID/BRESP stay stable until BREADY.
  - On BVALID&BREADY: BVALID=0, next cycle IDLE with AWREADY=1.
  - Minimum turnaround: 1 cycle AW, N beats, 1 cycle B, 1 idle.
- WVALID in IDLE or RESP is ignored (WREADY=0).
- Reset mid-burst aborts immediately: no B response is issued, and partially written words remain in memory.

Test Plan:
- INCR, AWADDR=0x10, AWLEN=3, DATA_WIDTH=32, WDATA=A0..A3, WSTRB=F -> mem writes at words 4,5,6,7; BRESP=00; BID=AWID.
- WRAP, AWADDR=0x38, AWLEN=3 -> word sequence 14,15,12,13; BRESP=00. Same with AWLEN=2 -> no mem_we, 3 beats drained, BRESP=10.
- FIXED, AWADDR=0x20, AWLEN=2, WSTRB=1,2,4 -> three writes at word 8 with those strobes; BRESP=00.
- WLAST asserted on beat 2 of AWLEN=3 -> 4 beats still accepted; BRESP=10. AWSIZE=1 with DATA_WIDTH=32 -> no writes, SLVERR.
- INCR starting at word MEM_DEPTH-2, AWLEN=3 -> 2 writes, last 2 dropped, BRESP=10. BREADY held 0 for 5 cycles -> BVALID/BRESP stable, AWREADY stays 0.
- ARESETn pulsed low during beat 2 -> AWREADY=WREADY=BVALID=0 asynchronously, no B; AWREADY=1 one edge after release; a new burst then completes with OKAY.
